// File: rtl/sdram_refresh_arbiter_if.sv
// Handshake and status bundle between the Z2 bus side (master) and the
// SDRAM refresh arbiter (slave).
interface sdram_refresh_arbiter_if;
  logic       cpu_req;
  logic       cpu_gnt;
  logic       cmd_pre_all;
  logic       cmd_refresh;
  logic       cmd_mrs;
  logic       ready;
  logic [3:0] ref_pending;
  logic       ref_overflow;

  modport master (
    output cpu_req,
    input  cpu_gnt, cmd_pre_all, cmd_refresh, cmd_mrs, ready, ref_pending, ref_overflow
  );

  modport slave (
    input  cpu_req,
    output cpu_gnt, cmd_pre_all, cmd_refresh, cmd_mrs, ready, ref_pending, ref_overflow
  );
endinterface

// File: rtl/sdram_refresh_arbiter.sv
// SDRAM power-up init, auto-refresh scheduling with bounded debt, and CPU grant.
// Optional macro SDRAM_OPPORTUNISTIC_REFRESH_EN: refresh early when idle and debt-free.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// INIT_WAIT | post-reset idle for INIT_DELAY edges
// INIT_PRE  | PRECHARGE ALL issued, waiting TRP
// INIT_REF1 | first init AUTO REFRESH issued, waiting TRC
// INIT_REF2 | second init AUTO REFRESH issued, waiting TRC
// INIT_MRS  | MODE REGISTER SET issued, waiting TMRD
// IDLE      | array free; one arbitration decision per cycle
// REFRESH   | AUTO REFRESH issued on entry, array busy for TRC cycles
// CPU       | array granted to the Z2 bus while cpu_req stays high
module sdram_refresh_arbiter #(
  parameter int unsigned INIT_DELAY       = 10000,
  parameter int unsigned REFRESH_INTERVAL = 780,
  parameter int unsigned TRP              = 2,
  parameter int unsigned TRC              = 7,
  parameter int unsigned TMRD             = 2,
  parameter int unsigned URGENT_THRESH    = 4,
  parameter int unsigned MAX_PENDING      = 8
) (
  input logic                    MEMCLK,
  input logic                    RESET_n,
  sdram_refresh_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(INIT_DELAY + TRP + TRC + TMRD + 1);
  localparam int unsigned TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]    URGENT     = 4'(URGENT_THRESH);
  localparam logic [3:0]    PEND_MAX   = 4'(MAX_PENDING);
`ifdef SDRAM_OPPORTUNISTIC_REFRESH_EN
  localparam logic [TW-1:0] TIMER_HALF = TW'(REFRESH_INTERVAL / 2);
`endif

  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT_PRE,
    INIT_REF1,
    INIT_REF2,
    INIT_MRS,
    IDLE,
    REFRESH,
    CPU
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q;
  logic [3:0]    pending_q;
  logic          overflow_q;
  logic          ready_q, ready_d;
  logic          gnt_q, gnt_d;
  logic          pre_q, pre_d;
  logic          ref_q, ref_d;
  logic          mrs_q, mrs_d;
  logic          dec;
  logic          opp_go;
  logic          cnt_done;
  logic          credit;

  assign cnt_done = (cnt_q == '0);

  // Down-counter phase timer: a state entered with cnt=N-1 leaves N edges later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    gnt_d   = 1'b0;
    pre_d   = 1'b0;
    ref_d   = 1'b0;
    mrs_d   = 1'b0;
    dec     = 1'b0;
    opp_go  = 1'b0;
    case (state_q)
      INIT_WAIT: begin
        if (cnt_done) begin
          state_d = INIT_PRE;
          cnt_d   = CW'(TRP - 1);
          pre_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      INIT_PRE: begin
        if (cnt_done) begin
          state_d = INIT_REF1;
          cnt_d   = CW'(TRC - 1);
          ref_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      INIT_REF1: begin
        if (cnt_done) begin
          state_d = INIT_REF2;
          cnt_d   = CW'(TRC - 1);
          ref_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      INIT_REF2: begin
        if (cnt_done) begin
          state_d = INIT_MRS;
          cnt_d   = CW'(TMRD - 1);
          mrs_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      INIT_MRS: begin
        if (cnt_done) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      IDLE: begin
        // Urgent debt beats the CPU; below threshold the CPU wins ties.
        if ((pending_q >= URGENT) || (!bus.cpu_req && (pending_q != '0))) begin
          state_d = REFRESH;
          cnt_d   = CW'(TRC - 1);
          ref_d   = 1'b1;
          dec     = 1'b1;
        end else if (bus.cpu_req) begin
          state_d = CPU;
          gnt_d   = 1'b1;
        end
`ifdef SDRAM_OPPORTUNISTIC_REFRESH_EN
        else if (timer_q >= TIMER_HALF) begin
          state_d = REFRESH;
          cnt_d   = CW'(TRC - 1);
          ref_d   = 1'b1;
          opp_go  = 1'b1;
        end
`endif
      end
      REFRESH: begin
        if (cnt_done) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CPU: begin
        if (bus.cpu_req) begin
          gnt_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = INIT_WAIT;
        cnt_d   = CW'(INIT_DELAY);
      end
    endcase
  end

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= INIT_WAIT;
      cnt_q   <= CW'(INIT_DELAY);
      ready_q <= 1'b0;
      gnt_q   <= 1'b0;
      pre_q   <= 1'b0;
      ref_q   <= 1'b0;
      mrs_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      gnt_q   <= gnt_d;
      pre_q   <= pre_d;
      ref_q   <= ref_d;
      mrs_q   <= mrs_d;
    end
  end

  // An early refresh that restarts the timer also covers a credit due that cycle.
  assign credit = ready_q && (timer_q == TIMER_LAST) && !opp_go;

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      timer_q <= '0;
    end else if (!ready_q || opp_go || (timer_q == TIMER_LAST)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else if (credit && !dec) begin
      if (pending_q == PEND_MAX) begin
        overflow_q <= 1'b1;
      end else begin
        pending_q <= pending_q + 4'd1;
      end
    end else if (dec && !credit) begin
      pending_q <= pending_q - 4'd1;
    end
  end

  assign bus.cpu_gnt      = gnt_q;
  assign bus.cmd_pre_all  = pre_q;
  assign bus.cmd_refresh  = ref_q;
  assign bus.cmd_mrs      = mrs_q;
  assign bus.ready        = ready_q;
  assign bus.ref_pending  = pending_q;
  assign bus.ref_overflow = overflow_q;

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// Directed bench for sdram_refresh_arbiter with short timing parameters;
// edge numbers below count MEMCLK rises since the last reset release.
module tb_sdram_refresh_arbiter;
  logic MEMCLK;
  logic RESET_n;

  sdram_refresh_arbiter_if bus ();

  sdram_refresh_arbiter #(
    .INIT_DELAY      (20),
    .REFRESH_INTERVAL(50),
    .TRP             (2),
    .TRC             (4),
    .TMRD            (2),
    .URGENT_THRESH   (4),
    .MAX_PENDING     (8)
  ) dut (
    .MEMCLK (MEMCLK),
    .RESET_n(RESET_n),
    .bus    (bus)
  );

  initial MEMCLK = 1'b0;
  always #5 MEMCLK = ~MEMCLK;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int inv_err = 0;
  int e_pre, e_ref1, e_ref2, e_mrs, e_rdy, e_gnt, n_cmd;
  int r_first, r_last, r_count;

  always @(negedge MEMCLK) begin
    if (RESET_n === 1'b1) begin
      if ((32'(bus.cmd_pre_all) + 32'(bus.cmd_refresh) + 32'(bus.cmd_mrs)) > 1)
        inv_err++;
      if (bus.cpu_gnt && (bus.cmd_pre_all || bus.cmd_refresh || bus.cmd_mrs))
        inv_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge MEMCLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic release_reset();
    tick();
    RESET_n = 1'b1;
    cyc = -1;
  endtask

  task automatic init_run(input int last);
    e_pre = -1; e_ref1 = -1; e_ref2 = -1; e_mrs = -1; e_rdy = -1; e_gnt = -1; n_cmd = 0;
    while (cyc < last) begin
      tick();
      if (bus.cmd_pre_all) begin e_pre = cyc; n_cmd++; end
      if (bus.cmd_refresh) begin
        if (e_ref1 < 0) e_ref1 = cyc; else e_ref2 = cyc;
        n_cmd++;
      end
      if (bus.cmd_mrs) begin e_mrs = cyc; n_cmd++; end
      if (bus.ready && e_rdy < 0) e_rdy = cyc;
      if (bus.cpu_gnt && e_gnt < 0) e_gnt = cyc;
    end
  endtask

  task automatic count_refs(input int last);
    r_first = -1; r_last = -1; r_count = 0;
    while (cyc < last) begin
      tick();
      if (bus.cmd_refresh) begin
        if (r_first < 0) r_first = cyc;
        r_last = cyc;
        r_count++;
      end
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {21'd0, bus.cpu_gnt, bus.cmd_pre_all, bus.cmd_refresh, bus.cmd_mrs,
            bus.ready, bus.ref_overflow, bus.ref_pending};
  endfunction

  initial begin
    RESET_n = 1'b0;
    bus.cpu_req = 1'b1;
    tick();
    tick();
    chk("reset_outputs", all_outs(), 0);

    // Init with cpu_req held high from release.
    release_reset();
    init_run(33);
    chk("init_pre_edge", e_pre, 20);
    chk("init_ref1_edge", e_ref1, 22);
    chk("init_ref2_edge", e_ref2, 26);
    chk("init_mrs_edge", e_mrs, 30);
    chk("init_cmd_count", n_cmd, 4);
    chk("init_ready_edge", e_rdy, 32);
    chk("init_gnt_edge", e_gnt, 33);

    // Long grant: credits at 82,132,182,232.
    run_to(263);
    chk("grant_pending4", bus.ref_pending, 4);
    chk("grant_held", bus.cpu_gnt, 1);
    bus.cpu_req = 1'b0;
    tick();
    chk("grant_drop", bus.cpu_gnt, 0);
    count_refs(281);
    chk("drain4_first", r_first, 265);
    chk("drain4_last", r_last, 280);
    chk("drain4_count", r_count, 4);
    chk("drain4_pending", bus.ref_pending, 0);

    // Idle steady state: credit at 332, refresh the next edge.
    run_to(332);
    chk("idle_credit", bus.ref_pending, 1);
    chk("idle_no_ref_yet", bus.cmd_refresh, 0);
    tick();
    chk("idle_ref", bus.cmd_refresh, 1);
    chk("idle_pending0", bus.ref_pending, 0);
    run_to(383);
    chk("idle_ref_next", bus.cmd_refresh, 1);

    // Request during a refresh waits out TRC.
    bus.cpu_req = 1'b1;
    run_to(387);
    chk("req_waits_trc", bus.cpu_gnt, 0);
    tick();
    chk("req_gnt_after_trc", bus.cpu_gnt, 1);

    // Debt of 5, then a fresh request in IDLE: 5 and 4 are both urgent.
    run_to(640);
    chk("debt5", bus.ref_pending, 5);
    bus.cpu_req = 1'b0;
    tick();
    chk("debt5_gnt_drop", bus.cpu_gnt, 0);
    bus.cpu_req = 1'b1;
    tick();
    chk("urgent_ref_first", bus.cmd_refresh, 1);
    chk("urgent_no_gnt", bus.cpu_gnt, 0);
    chk("urgent_pending4", bus.ref_pending, 4);
    run_to(647);
    chk("urgent_ref_second", bus.cmd_refresh, 1);
    run_to(651);
    chk("urgent_gnt_wait", bus.cpu_gnt, 0);
    tick();
    chk("urgent_gnt", bus.cpu_gnt, 1);
    chk("urgent_pending3", bus.ref_pending, 3);

    // Saturation: 8 reached at 882, credit at 932 is lost.
    run_to(931);
    chk("sat_pending8", bus.ref_pending, 8);
    chk("sat_no_ovf_yet", bus.ref_overflow, 0);
    tick();
    chk("sat_ovf", bus.ref_overflow, 1);
    chk("sat_pending_hold", bus.ref_pending, 8);
    run_to(935);
    bus.cpu_req = 1'b0;
    count_refs(975);
    chk("drain8_first", r_first, 937);
    chk("drain8_last", r_last, 972);
    chk("drain8_count", r_count, 8);
    run_to(980);
    chk("drain8_pending", bus.ref_pending, 0);
    chk("ovf_sticky", bus.ref_overflow, 1);
    run_to(983);
    chk("post_drain_ref", bus.cmd_refresh, 1);

    // Reset in the middle of a refresh.
    RESET_n = 1'b0;
    #1;
    chk("rst_mid_refresh", all_outs(), 0);
    release_reset();
    init_run(33);
    chk("replay1_pre", e_pre, 20);
    chk("replay1_ref1", e_ref1, 22);
    chk("replay1_ref2", e_ref2, 26);
    chk("replay1_mrs", e_mrs, 30);
    chk("replay1_cmds", n_cmd, 4);
    chk("replay1_ready", e_rdy, 32);
    chk("replay1_no_gnt", e_gnt, -1);
    run_to(81);
    chk("first_credit_pre", bus.ref_pending, 0);
    tick();
    chk("first_credit", bus.ref_pending, 1);
    tick();
    chk("first_idle_ref", bus.cmd_refresh, 1);
    chk("first_idle_pending", bus.ref_pending, 0);

    // Reset in the middle of a grant.
    bus.cpu_req = 1'b1;
    run_to(90);
    chk("pre_rst_gnt", bus.cpu_gnt, 1);
    RESET_n = 1'b0;
    #1;
    chk("rst_mid_grant", all_outs(), 0);
    release_reset();
    init_run(33);
    chk("replay2_pre", e_pre, 20);
    chk("replay2_ref1", e_ref1, 22);
    chk("replay2_ref2", e_ref2, 26);
    chk("replay2_mrs", e_mrs, 30);
    chk("replay2_ready", e_rdy, 32);
    chk("replay2_gnt", e_gnt, 33);

    chk("invariants", inv_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
